lsu: RTL and testbench



---
 rtl/lsu_pkg.sv | 73 +++++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu.sv | 160 ++++++++++++++++
 tb/tb_lsu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I size codes,
// FSM states, the registered bus payload and request decode helpers.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 8;

  // RV32I funct3 size codes
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // Everything driven onto the data-memory bus during a request
  typedef struct packed {
    logic              we;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } lsu_bus_t;

  // 1 when the request must be rejected: illegal size code or misaligned
  function automatic logic lsu_bad_req(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic illegal;
    logic misal;
    if (we) illegal = (f3 > LSU_W);
    else    illegal = !(f3 inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
    case (f3[1:0])
      2'b01:   misal = off[0];
      2'b10:   misal = (off != 2'b00);
      default: misal = 1'b0;
    endcase
    return illegal | misal;
  endfunction

  // Bus payload for an accepted request; loads drive no strobes or data
  function automatic lsu_bus_t lsu_bus_build(input logic we, input logic [2:0] f3,
                                             input logic [XLEN-1:0] addr,
                                             input logic [XLEN-1:0] data);
    lsu_bus_t b;
    b.we    = we;
    b.addr  = {addr[XLEN-1:2], 2'b00};
    b.wdata = '0;
    b.wstrb = '0;
    if (we) begin
      case (f3[1:0])
        2'b00: begin
          b.wdata = {4{data[7:0]}};
          b.wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          b.wdata = {2{data[15:0]}};
          b.wstrb = 4'b0011 << addr[1:0];
        end
        default: begin
          b.wdata = data;
          b.wstrb = 4'b1111;
        end
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load extraction: picks the byte/half at the given offset of a read word
// and sign- or zero-extends it according to funct3.
//   rdata  : raw bus read word
//   offset : byte offset addr[1:0]
//   funct3 : load size code
//   ext_c  : extended result (combinational)
module load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LSU_B:   ext_c = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   ext_c = {{16{shifted[15]}}, shifted[15:0]};
      LSU_BU:  ext_c = {24'd0, shifted[7:0]};
      LSU_HU:  ext_c = {16'd0, shifted[15:0]};
      default: ext_c = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: takes an effective address from the ALU, performs one
// byte/half/word access on a valid/ack data bus and returns the extended
// load value. Misaligned/illegal requests and bus timeouts complete with an
// error flag and no bus activity.
//   req_*        : request from execute (accepted when req_ready)
//   rd_data/done : result and one-cycle completion pulse
//   err_*        : error flags, pulse with done
//   mem_*        : data-memory bus
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  output logic [XLEN-1:0]   rd_data,
  output logic              done,
  output logic              err_misaligned,
  output logic              err_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e       state_q, state_d;
  lsu_bus_t         bus_q, bus_d;
  logic             mem_req_q, mem_req_d;
  logic             ready_q, ready_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rd_q, rd_d;
  logic             done_q, done_d;
  logic             errm_q, errm_d;
  logic             errt_q, errt_d;
  logic [XLEN-1:0]  load_ext_c;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (funct3_q),
    .ext_c  (load_ext_c)
  );

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    bus_d     = bus_q;
    mem_req_d = mem_req_q;
    ready_d   = ready_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    rd_d      = '0;
    done_d    = 1'b0;
    errm_d    = 1'b0;
    errt_d    = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid && ready_q) begin
          funct3_d = req_funct3;
          off_d    = alu_result[1:0];
          ready_d  = 1'b0;
          if (lsu_bad_req(req_we, req_funct3, alu_result[1:0])) begin
            state_d = LSU_RESP;
            done_d  = 1'b1;
            errm_d  = 1'b1;
          end else begin
            state_d   = LSU_REQ;
            mem_req_d = 1'b1;
            cnt_d     = '0;
            bus_d     = lsu_bus_build(req_we, req_funct3, alu_result, store_data);
          end
        end
      end
      LSU_REQ: begin
        // Ack takes priority over the limit in the same cycle
        if (mem_ack) begin
          state_d   = LSU_RESP;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          bus_d     = '0;
          rd_d      = bus_q.we ? '0 : load_ext_c;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d   = LSU_RESP;
          done_d    = 1'b1;
          errt_d    = 1'b1;
          mem_req_d = 1'b0;
          bus_d     = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_RESP: begin
        state_d = LSU_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d   = LSU_IDLE;
        ready_d   = 1'b1;
        mem_req_d = 1'b0;
        bus_d     = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LSU_IDLE;
      bus_q     <= '0;
      mem_req_q <= 1'b0;
      ready_q   <= 1'b1;
      funct3_q  <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      done_q    <= 1'b0;
      errm_q    <= 1'b0;
      errt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bus_q     <= bus_d;
      mem_req_q <= mem_req_d;
      ready_q   <= ready_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      done_q    <= done_d;
      errm_q    <= errm_d;
      errt_q    <= errt_d;
    end
  end

  assign req_ready      = ready_q;
  assign rd_data        = rd_q;
  assign done           = done_q;
  assign err_misaligned = errm_q;
  assign err_timeout    = errt_q;
  assign mem_req        = mem_req_q;
  assign mem_we         = bus_q.we;
  assign mem_addr       = bus_q.addr;
  assign mem_wdata      = bus_q.wdata;
  assign mem_wstrb      = bus_q.wstrb;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed test-plan cases plus randomized
// accesses compared against a byte-lane reference model.
module tb_lsu;

  localparam int unsigned TO = 8;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] alu_result, store_data, rd_data;
  logic        done, err_misaligned, err_timeout;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad   = 0;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .alu_result(alu_result),
    .store_data(store_data), .rd_data(rd_data), .done(done),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference rule: which requests are rejected
  function automatic bit model_bad(input bit we, input int f3, input int off);
    int sz;
    sz = f3 % 4;
    if (we && f3 > 2) return 1'b1;
    if (!we && (f3 == 3 || f3 >= 6)) return 1'b1;
    return (sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0);
  endfunction

  // One full access: drive, check each bus cycle, check completion and the
  // cycle after. ack_at = mem_req cycle number carrying the ack (0 = never).
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input int ack_at,
                            input logic [31:0] rdata, input string tag);
    int          off, nb;
    bit          err, tmo;
    logic [3:0]  ewstrb;
    logic [31:0] ewdata, erd;
    longint      v;
    off = int'(addr[1:0]);
    nb  = 1 << int'(f3[1:0]);
    err = model_bad(we, int'(f3), off);
    tmo = !err && (ack_at < 1 || ack_at > int'(TO));
    ewstrb = '0; ewdata = '0; erd = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= off && i < off + nb) ewstrb[i] = 1'b1;
          ewdata[8*i +: 8] = data[8*(i % nb) +: 8];
        end
      end else begin
        v = longint'(rdata >> (8 * off)) & ((64'sd1 <<< (8 * nb)) - 64'sd1);
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (64'sd1 <<< (8 * nb));
        erd = 32'(v);
      end
    end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; alu_result = addr; store_data = data;
    @(posedge clk);
    #1;
    // Request inputs are don't-care after acceptance; keep them busy
    req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
    alu_result = $urandom; store_data = $urandom;

    if (err) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      total++;
      if ({done, err_misaligned, err_timeout, mem_req, req_ready, rd_data} !== {5'b11000, 32'd0})
        begin bad++; $display("FAIL %s err_resp got=%h exp=%h", tag,
          {done, err_misaligned, err_timeout, mem_req, req_ready, rd_data}, {5'b11000, 32'd0}); end
    end else begin
      for (int n = 1; n <= int'(TO); n++) begin
        @(negedge clk);
        total++;
        if ({mem_req, done, req_ready, mem_we, mem_addr, mem_wstrb} !==
            {3'b100, we, {addr[31:2], 2'b00}, ewstrb})
          begin bad++; $display("FAIL %s bus_cyc%0d got=%h exp=%h", tag, n,
            {mem_req, done, req_ready, mem_we, mem_addr, mem_wstrb},
            {3'b100, we, {addr[31:2], 2'b00}, ewstrb}); end
        if (we) begin
          total++;
          if (mem_wdata !== ewdata)
            begin bad++; $display("FAIL %s wdata_cyc%0d got=%h exp=%h", tag, n, mem_wdata, ewdata); end
        end
        mem_ack   = (n == ack_at);
        mem_rdata = (n == ack_at) ? rdata : $urandom;
        if (n == ack_at) break;
      end
      @(negedge clk);
      mem_ack = 1'($urandom); mem_rdata = $urandom;
      total++;
      if ({done, err_misaligned, err_timeout, mem_req, req_ready, rd_data} !==
          {2'b10, tmo, 2'b00, tmo ? 32'd0 : erd})
        begin bad++; $display("FAIL %s done got=%h exp=%h", tag,
          {done, err_misaligned, err_timeout, mem_req, req_ready, rd_data},
          {2'b10, tmo, 2'b00, tmo ? 32'd0 : erd}); end
    end

    // Completion cycle had random req_valid: it must not have been taken
    @(negedge clk);
    req_valid = 1'b0; mem_ack = 1'b0;
    total++;
    if ({done, req_ready, mem_req, err_misaligned, err_timeout} !== 5'b01000)
      begin bad++; $display("FAIL %s after_done got=%b exp=%b", tag,
        {done, req_ready, mem_req, err_misaligned, err_timeout}, 5'b01000); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    alu_result = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rd_data, done,
         err_misaligned, err_timeout} !== {1'b1, 105'd0})
      begin bad++; $display("FAIL reset_values got=%h exp=%h",
        {req_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rd_data, done,
         err_misaligned, err_timeout}, {1'b1, 105'd0}); end
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    run_access(1'b0, 3'b010, 32'h0000_1004, 32'h0, 3, 32'hDEAD_BEEF, "lw_1004");
    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_0011, "lb_1003");
    run_access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 2, 32'h80FF_0011, "lbu_1003");
    run_access(1'b0, 3'b101, 32'h0000_1002, 32'h0, 1, 32'h80FF_0011, "lhu_1002");
    run_access(1'b0, 3'b001, 32'h0000_1002, 32'h0, 4, 32'h80FF_0011, "lh_1002");
  endtask

  task automatic test_stores();
    run_access(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 2, 32'h5555_5555, "sh_2002");
    run_access(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 1, 32'h0, "sb_2001");
    run_access(1'b1, 3'b010, 32'h0000_2008, 32'h0BAD_F00D, 5, 32'h0, "sw_2008");
  endtask

  task automatic test_errors();
    run_access(1'b0, 3'b010, 32'h0000_1002, 32'h0, 1, 32'h0, "lw_misal");
    run_access(1'b0, 3'b011, 32'h0000_1000, 32'h0, 1, 32'h0, "ld_f3_011");
    run_access(1'b0, 3'b111, 32'h0000_1000, 32'h0, 1, 32'h0, "ld_f3_111");
    run_access(1'b1, 3'b001, 32'h0000_2001, 32'h0, 1, 32'h0, "sh_misal");
    run_access(1'b1, 3'b100, 32'h0000_2000, 32'h0, 1, 32'h0, "st_f3_100");
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0, "tmo_noack");
    run_access(1'b0, 3'b010, 32'h0000_3004, 32'h0, int'(TO), 32'h1357_9BDF, "ack_at_limit");
    run_access(1'b1, 3'b010, 32'h0000_3008, 32'h7777_8888, int'(TO) + 1, 32'h0, "tmo_late_ack");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; alu_result = 32'h40;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1)
      begin bad++; $display("FAIL rst_mid_req got=%b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({req_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rd_data, done,
         err_misaligned, err_timeout} !== {1'b1, 105'd0})
      begin bad++; $display("FAIL rst_mid_async got=%h exp=%h",
        {req_ready, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rd_data, done,
         err_misaligned, err_timeout}, {1'b1, 105'd0}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, done, req_ready} !== 3'b001)
      begin bad++; $display("FAIL rst_mid_idle got=%b exp=001", {mem_req, done, req_ready}); end
    run_access(1'b1, 3'b010, 32'h0000_0010, 32'hCAFE_F00D, 2, 32'h0, "sw_after_rst");
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 3'b010, 32'h0000_0100, 32'h0, 1, 32'hA5A5_5A5A, "b2b_0");
    run_access(1'b0, 3'b001, 32'h0000_0101, 32'h0, 1, 32'h0, "b2b_err");
    run_access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_003C, 1, 32'h0, "b2b_1");
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom);
      f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom);
      addr = $urandom;
      // Mostly aligned so the bus path gets exercised
      if ($urandom_range(0, 3) != 0) addr[1:0] = f3[1:0] == 2'b10 ? 2'b00 :
                                                  f3[1:0] == 2'b01 ? {1'($urandom), 1'b0} : addr[1:0];
      run_access(we, f3, addr, $urandom, int'($urandom_range(0, TO + 1)), $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
